// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous word memory (1-cycle read
// latency) between two requesters with round-robin arbitration and an
// optional bounded lock.
//   Port 0 = CPU load/store, port 1 = program loader / debug.
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   req/lock/we[1:0]  per-port request, lock request (qualified by req), write
//   addrN/wdataN      per-port word address / write data
//   gnt[1:0]          combinational grant; access issued when req[i]&gnt[i]
//   rvalid[1:0]       read data valid, one cycle after a granted read
//   rdata             shared read data (0 unless some rvalid bit is set)
//   mem_*             memory-side access, driven from the winning port
module mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        req,
  input  logic [1:0]        lock,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d, cnt_inc;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [1:0]  gnt_raw;
  logic        own_port, win;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      rvalid_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // lock_cnt counts granted cycles of the current ownership including the
  // entry grant; the grant that brings it to LOCK_MAX is the last one.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    gnt_raw    = '0;
    own_port   = (state_q == OWN1);
    win        = 1'b0;
    cnt_inc    = lock_cnt_q + 8'd1;
    if (state_q != IDLE && req[own_port] && lock[own_port]) begin
      gnt_raw[own_port] = 1'b1;
      if (cnt_inc == LOCK_MAX_C) begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end else begin
        lock_cnt_d = cnt_inc;
      end
    end else begin
      // Idle rules; also covers the same-cycle fallback when an owner drops lock.
      state_d    = IDLE;
      lock_cnt_d = '0;
      win        = (req == 2'b11) ? ~last_q : req[1];
      if (|req) begin
        gnt_raw[win] = 1'b1;
        last_d       = win;
        // With LOCK_MAX==1 the entry grant already exhausts the lock.
        if (lock[win] && LOCK_MAX > 1) begin
          state_d    = win ? OWN1 : OWN0;
          lock_cnt_d = 8'd1;
        end
      end
    end
  end

  assign rvalid_d = gnt_raw & ~we;

  // Grant is gated by reset only on the outputs so the flops never see RST
  // through their D path.
  assign gnt       = RST ? 2'b00 : gnt_raw;
  assign mem_en    = |gnt;
  assign mem_we    = |(gnt & we);
  assign mem_addr  = gnt[1] ? addr1  : (gnt[0] ? addr0  : '0);
  assign mem_wdata = gnt[1] ? wdata1 : (gnt[0] ? wdata0 : '0);

  assign rvalid = rvalid_q;
  assign rdata  = (|rvalid_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int LM = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [1:0]    req, lock, we;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    gnt, rvalid;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .CLK(CLK), .RST(RST), .req(req), .lock(lock), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Environment memory: synchronous, 1-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] mem_rd_q = '0;
  assign mem_rdata = mem_rd_q;
  always @(posedge CLK) begin
    if (mem_en && mem_we)  mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rd_q      <= mem[mem_addr];
  end

  // Reference model state: who owns the lock, how many grants it has had,
  // who was granted last, plus a shadow copy of memory contents.
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            owner, cnt, last, w;
  logic [1:0]    exp_gnt, exp_rv;
  logic [DW-1:0] exp_rd;
  int            errors = 0;
  int            checks = 0;
  logic [1:0]    plan5 [10];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; cnt = 0; last = 1; w = -1;
    exp_rv = '0; exp_rd = '0;
  endtask

  task automatic predict();
    w = -1;
    if (owner >= 0 && req[owner] && lock[owner]) w = owner;
    else if (req == 2'b01) w = 0;
    else if (req == 2'b10) w = 1;
    else if (req == 2'b11) w = 1 - last;
    exp_gnt = 2'b00;
    if (w >= 0) exp_gnt[w] = 1'b1;
  endtask

  task automatic check_outputs();
    predict();
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("mem_en", 32'(mem_en), 32'(w >= 0));
    chk("mem_we", 32'(mem_we), 32'((w >= 0) ? we[w] : 1'b0));
    if (w >= 0) begin
      chk("mem_addr", 32'(mem_addr), 32'((w == 1) ? addr1 : addr0));
      if (we[w]) chk("mem_wdata", 32'(mem_wdata), 32'((w == 1) ? wdata1 : wdata0));
    end
    chk("rvalid", 32'(rvalid), 32'(exp_rv));
    chk("rdata", 32'(rdata), 32'(exp_rd));
  endtask

  task automatic model_update();
    logic [AW-1:0] a;
    if (w >= 0) begin
      a = (w == 1) ? addr1 : addr0;
      exp_rv = 2'b00;
      exp_rd = '0;
      if (we[w]) shadow[a] = (w == 1) ? wdata1 : wdata0;
      else begin
        exp_rv[w] = 1'b1;
        exp_rd    = shadow[a];
      end
      if (owner == w && lock[w]) begin
        cnt++;
        if (cnt == LM) begin owner = -1; cnt = 0; end
      end else if (lock[w] && LM > 1) begin
        owner = w; cnt = 1;
      end else begin
        owner = -1; cnt = 0;
      end
      last = w;
    end else begin
      owner = -1; cnt = 0; exp_rv = '0; exp_rd = '0;
    end
  endtask

  task automatic check_and_clock();
    check_outputs();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic cycle();
    @(negedge CLK);
    check_and_clock();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_gnt"},    32'(gnt),      32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid),   32'd0);
    chk({tag, "_mem_en"}, 32'(mem_en),   32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we),   32'd0);
    chk({tag, "_addr"},   32'(mem_addr), 32'd0);
    chk({tag, "_wdata"},  32'(mem_wdata),32'd0);
    chk({tag, "_rdata"},  32'(rdata),    32'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1; req = 2'b11; lock = 2'b11; we = 2'b00;
    #1 reset_checks("rst");
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0; req = 2'b00; lock = 2'b00;
    model_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = DW'($urandom);
      shadow[i] = mem[i];
    end
    mem[5] = 16'h6001; shadow[5] = 16'h6001;
    RST = 1'b1; req = '0; lock = '0; we = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    model_reset();

    // Reset state, then a single read on port 0.
    do_reset();
    req = 2'b01; we = 2'b00; addr0 = 10'd5;
    @(negedge CLK);
    chk("t1_gnt", 32'(gnt), 32'h1);
    check_and_clock();
    req = 2'b00;
    @(negedge CLK);
    chk("t1_rvalid", 32'(rvalid), 32'h1);
    chk("t1_rdata", 32'(rdata), 32'h6001);
    check_and_clock();

    // Round-robin with both ports reading.
    do_reset();
    req = 2'b11; we = 2'b00; addr0 = 10'd1; addr1 = 10'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rr_gnt", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
      check_and_clock();
    end

    // Port 1 locked block write of addresses 0..3 while port 0 waits.
    addr0 = 10'd7;
    for (int i = 0; i < 4; i++) begin
      req = 2'b11; lock = 2'b10; we = 2'b10;
      addr1 = AW'(i); wdata1 = DW'($urandom);
      @(negedge CLK);
      chk("lockwr_gnt", 32'(gnt), 32'h2);
      check_and_clock();
    end
    lock = 2'b00; we = 2'b00;
    @(negedge CLK);
    chk("lockdrop_gnt", 32'(gnt), 32'h1);
    check_and_clock();
    req = 2'b00;
    cycle();

    // Forced release at LOCK_MAX with port 0 contending.
    plan5 = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    addr0 = 10'd9; addr1 = 10'd3;
    for (int i = 0; i < 10; i++) begin
      req = 2'b11; lock = 2'b10; we = 2'b00;
      @(negedge CLK);
      chk("lockmax_gnt", 32'(gnt), 32'(plan5[i]));
      check_and_clock();
    end

    // Reset while port 1 owns the lock with a read outstanding.
    req = 2'b11; lock = 2'b10; we = 2'b00;
    cycle();
    RST = 1'b1;
    #1 reset_checks("midrst");
    model_reset();
    @(negedge CLK);
    reset_checks("midrst_hold");
    @(posedge CLK); #1;
    RST = 1'b0; req = 2'b01; lock = 2'b00; addr0 = 10'd5;
    model_reset();
    @(negedge CLK);
    chk("postrst_gnt", 32'(gnt), 32'h1);
    check_and_clock();
    req = 2'b00;
    cycle();

    // Random traffic; requesters hold their request until granted.
    w = -1;
    for (int n = 0; n < 500; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req[p] || w == p) begin
          req[p] = ($urandom_range(0, 9) < 7);
          we[p]  = 1'($urandom_range(0, 1));
          if (p == 0) begin
            addr0 = AW'($urandom_range(0, 15)); wdata0 = DW'($urandom);
          end else begin
            addr1 = AW'($urandom_range(0, 15)); wdata1 = DW'($urandom);
          end
        end
      end
      lock[0] = ($urandom_range(0, 3) == 0);
      lock[1] = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the CPU's single-port word memory between two requesters.
  - Port 0 is the CPU load/store path.
  - Port 1 is the program loader/debug port that fills instruction and data memory before and between runs.
- Performs round-robin arbitration, with an optional bounded lock so the loader can write a contiguous block without interleaving.
- Sits between the requesters and the synchronous memory, which has 1-cycle read latency.

Parameters:
- ADDR_W, 10, word-address width.
- DATA_W, 16, data word width.
- LOCK_MAX, 16, maximum consecutive granted cycles a locked owner may hold the memory before a forced release (range 1..255).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- req  in  2  per-port access request; bit i = port i.
- lock  in  2  per-port lock request; qualified by req.
- we  in  2  per-port write enable.
- addr0, addr1  in  ADDR_W  per-port word address.
- wdata0, wdata1  in  DATA_W  per-port write data.
- gnt  out  2  per-port grant, combinational; access is issued in a cycle where req[i]&gnt[i].
- rvalid  out  2  per-port read-data valid, 1 cycle after a granted read.
- rdata  out  DATA_W  shared read data; valid only when some rvalid bit is set.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en&!mem_we.

Behaviour:
- Reset (asynchronous, while RST=1):
  - state=IDLE, last=1, lock_cnt=0.
  - gnt=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Requester rule: hold req/we/addr/wdata stable until the cycle gnt is seen. The transfer completes in that cycle. At most one gnt bit is set in any cycle.
- States: IDLE, OWN0, OWN1.
- In IDLE:
  - Single requester i: gnt[i]=1.
  - Both requesting: grant the port != last.
  - On a grant to i, last<=i at the clock edge.
  - If req[i]&lock[i] is set on the granted cycle, go to OWNi with lock_cnt<=1.
- In OWNi:
  - Only port i can be granted; gnt[i]=req[i]; the other port is blocked.
  - lock_cnt increments on each granted cycle.
  - Exit to IDLE when either:
    - req[i]&lock[i]==0 (that cycle grants normally by round-robin from IDLE rules, same cycle), or
    - a grant occurs with lock_cnt==LOCK_MAX (forced release; the next cycle is IDLE and the other port wins any conflict since last=i).
- Memory drive (combinational from the winner):
  - mem_en=|gnt.
  - mem_we, mem_addr, mem_wdata = the granted port's signals.
  - With no grant: mem_en=0, mem_we=0.
- Read return:
  - A granted read on port i sets a registered tag.
  - On the next cycle: rvalid[i]=1 and rdata=mem_rdata (passed through; rdata holds 0 otherwise).
  - Back-to-back reads to alternating ports are legal. rvalid follows grant order with exactly 1-cycle latency.
- Granted writes produce no rvalid.
- Reset mid-lock or mid-read drops the ownership and the pending rvalid immediately; no stale rvalid after reset release.
- Read and write to the same address in consecutive cycles: the read observes the memory's result. The arbiter adds no forwarding.

Test Plan:
- Reset, then req=01, we=0, addr0=5 with mem[5]='h6001 -> gnt=01 the same cycle; next cycle rvalid=01, rdata='h6001.
- req=11 from IDLE after reset -> grants 01, then 10, then 01 on successive cycles while both are held; each completes in 1 cycle.
- Port 1 with lock=1, we=1, writes addr 0..3 while port 0 holds req -> gnt=10 for 4 cycles; lock drops -> port 0 granted that same cycle.
- LOCK_MAX=4: port 1 holds req&lock for 10 cycles with port 0 requesting -> gnt[1] for 4 cycles, gnt[0] for 1 cycle, then port 1 re-locks.
- Assert RST during OWN1 with a read outstanding -> gnt=0, rvalid=0, mem_en=0 immediately; after release, req=01 is granted in the first cycle.
